// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg
//   Shared constants and helpers for the pushbutton debouncer slice.
//   STABLE_CYCLES_SIM : default stability window used for simulation builds.
//                       Board builds override STABLE_CYCLES at instantiation
//                       (e.g. 500000 for a 10 ms window at 50 MHz).
//   cnt_width()       : stability counter width, never less than one bit.
package button_debouncer_pkg;

    localparam int unsigned STABLE_CYCLES_SIM = 4;

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// debounce_channel
//   One debounced pushbutton: 2-flop synchroniser followed by a stability
//   counter. dout flips only after the synchronised input has differed from
//   it for STABLE_CYCLES consecutive edges; any earlier return clears the
//   count.
//   Optional feature macro: BTN_PULSE_EN adds a registered one-cycle pulse
//   that rises together with a 0->1 transition of dout.
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high
//   din    in   raw asynchronous button level
//   dout   out  debounced level
//   pulse  out  rising-edge pulse (BTN_PULSE_EN only)
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_SIM
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
`ifdef BTN_PULSE_EN
    output logic pulse,
`endif
    output logic dout
);

    localparam int unsigned      CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter holds at zero while the synchronised level agrees with the
    // output, so it can never exceed CNT_LAST.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= din;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout = db_q;

`ifdef BTN_PULSE_EN
    logic pulse_q, pulse_d;

    assign pulse_d = ~db_q & db_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
`endif

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer
//   Synchronises and debounces N raw pushbuttons for downstream lab logic.
//   Pure wiring: N independent debounce_channel instances.
//   Optional feature macro: BTN_PULSE_EN exposes btn_pulse.
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   btn_in     in   [N] raw asynchronous button levels
//   btn_db     out  [N] debounced, synchronised levels
//   btn_pulse  out  [N] one-cycle rising-edge pulses (BTN_PULSE_EN only)
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned N             = 3,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_SIM
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_in,
`ifdef BTN_PULSE_EN
    output logic [N-1:0] btn_pulse,
`endif
    output logic [N-1:0] btn_db
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .din  (btn_in[i]),
`ifdef BTN_PULSE_EN
            .pulse(btn_pulse[i]),
`endif
            .dout (btn_db[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

    localparam int unsigned N = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_db;
    logic [N-1:0] btn_pulse;

    int unsigned tests  = 0;
    int unsigned fails  = 0;
    int unsigned edge_n = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .N            (N),
        .STABLE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
`ifdef BTN_PULSE_EN
        .btn_pulse(btn_pulse),
`endif
        .btn_db   (btn_db)
    );

`ifndef BTN_PULSE_EN
    assign btn_pulse = '0;
`endif

    // Advance one rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        $display("[TB] clk=%0d btn_in=%b btn_db=%b btn_pulse=%b",
                 edge_n, btn_in, btn_db, btn_pulse);
    endtask

    task automatic check(input string tag, input logic [N-1:0] exp_db,
                         input logic [N-1:0] exp_pulse);
        tests++;
        assert (btn_db === exp_db) else begin
            fails++;
            $error("FAIL %s btn_db: got %b expected %b (clk=%0d)", tag, btn_db, exp_db, edge_n);
        end
`ifdef BTN_PULSE_EN
        tests++;
        assert (btn_pulse === exp_pulse) else begin
            fails++;
            $error("FAIL %s btn_pulse: got %b expected %b (clk=%0d)", tag, btn_pulse, exp_pulse, edge_n);
        end
`else
        if (exp_pulse != exp_pulse) $display("[TB] unreachable");
`endif
    endtask

    // Hold btn_in at 'val'; btn_db must keep 'old_db' for 5 edges and become
    // 'new_db' on the 6th, with 'rise_pulse' on that edge, then quiet.
    task automatic settle(input string tag, input logic [N-1:0] val,
                          input logic [N-1:0] old_db, input logic [N-1:0] new_db,
                          input logic [N-1:0] rise_pulse);
        btn_in = val;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check(tag, old_db, '0);
        end
        tick();
        check(tag, new_db, rise_pulse);
        tick();
        check(tag, new_db, '0);
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 3'b111;

        // 1: reset dominates, then full latency from release
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", 3'b000, 3'b000);
        end
        reset = 1'b0;
        settle("release_all", 3'b111, 3'b000, 3'b111, 3'b111);
        settle("drop_all", 3'b000, 3'b111, 3'b000, 3'b000);

        // 2: single press
        settle("press0", 3'b001, 3'b000, 3'b001, 3'b001);

        // 3: short glitch on channel 1 is rejected
        btn_in = 3'b011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("glitch1", 3'b001, 3'b000);
        end
        btn_in = 3'b001;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("glitch1_after", 3'b001, 3'b000);
        end

        // 4: bouncing channel 2, count restarts from the last 0->1
        btn_in = 3'b101; tick(); check("bounce2", 3'b001, 3'b000);
        btn_in = 3'b001; tick(); check("bounce2", 3'b001, 3'b000);
        btn_in = 3'b101; tick(); check("bounce2", 3'b001, 3'b000);
        btn_in = 3'b001; tick(); check("bounce2", 3'b001, 3'b000);
        settle("bounce2_hold", 3'b101, 3'b001, 3'b101, 3'b100);

        // 5: releases debounce symmetrically and never pulse
        settle("release2", 3'b001, 3'b101, 3'b001, 3'b000);
        settle("release0", 3'b000, 3'b001, 3'b000, 3'b000);

        // 6: reset mid-count discards progress
        btn_in = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pre_reset", 3'b000, 3'b000);
        end
        reset = 1'b1;
        tick();
        check("mid_reset", 3'b000, 3'b000);
        reset = 1'b0;
        settle("post_reset", 3'b010, 3'b000, 3'b010, 3'b010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (clk=%0d)", edge_n);
        $fatal(1, "timeout");
    end

endmodule
